// File: rtl/wb_regfile.sv
// Writeback select and 2^ADDR_W x DATA_W architectural register file with two combinational read ports.
// Optional write-through bypass on the read ports when REGFILE_BYPASS_EN is defined.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wwreg,
  input  logic              wm2reg,
  input  logic [ADDR_W-1:0] wdestReg,
  input  logic [DATA_W-1:0] wr,
  input  logic [DATA_W-1:0] wdo,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] wbData,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  wr_count_q;
  logic [CNT_W-1:0]  wr_count_d;
  logic              commit;

  function automatic logic [DATA_W-1:0] wb_select(input logic              m2r,
                                                  input logic [DATA_W-1:0] alu,
                                                  input logic [DATA_W-1:0] mem);
    return m2r ? mem : alu;
  endfunction

  // Writeback select and commit qualification; r0 writes never commit.
  always_comb begin
    wbData = wb_select(wm2reg, wr, wdo);
    commit = wwreg && (wdestReg != '0);
  end

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      regs_d[wdestReg] = wbData;
      wr_count_d       = wr_count_q + CNT_W'(1);
    end
  end

  // Reset wins over a same-edge write, so the in-flight write is dropped and not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Read ports: r0 is hardwired to zero and takes precedence over any bypass.
  always_comb begin
    qa = regs_q[rs];
    qb = regs_q[rt];
`ifdef REGFILE_BYPASS_EN
    if (!rst && commit && (wdestReg == rs)) qa = wbData;
    if (!rst && commit && (wdestReg == rt)) qb = wbData;
`endif
    if (rs == '0) qa = '0;
    if (rt == '0) qb = '0;
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: scoreboard of expected read/count values checked by immediate assertions.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          wwreg;
  logic          wm2reg;
  logic [AW-1:0] wdestReg;
  logic [DW-1:0] wr;
  logic [DW-1:0] wdo;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic [DW-1:0] wbData;
  logic [CW-1:0] wr_count;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wwreg(wwreg), .wm2reg(wm2reg), .wdestReg(wdestReg),
    .wr(wr), .wdo(wdo), .rs(rs), .rt(rt), .qa(qa), .qb(qb),
    .wbData(wbData), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] model_regs [32];
  logic [CW-1:0] model_cnt;
  logic [DW-1:0] exp_q [$];
  int            n_checks;
  int            n_passed;

  task automatic expect_val(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] exp;
    exp = exp_q.pop_front();
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic en, input logic m2r, input logic [AW-1:0] dest,
                       input logic [DW-1:0] r, input logic [DW-1:0] d);
    wwreg    = en;
    wm2reg   = m2r;
    wdestReg = dest;
    wr       = r;
    wdo      = d;
  endtask

  // Advance one edge and update the reference model from what was driven.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
      model_cnt = '0;
    end else if (wwreg && wdestReg != '0) begin
      model_regs[wdestReg] = wm2reg ? wdo : wr;
      model_cnt = model_cnt + 4'd1;
    end
    #1;
  endtask

  task automatic read_check(input logic [AW-1:0] a, input logic [AW-1:0] b, input string tag);
    rs = a;
    rt = b;
    expect_val(model_regs[a]);
    expect_val(model_regs[b]);
    #1;
    check({tag, "_qa"}, qa);
    check({tag, "_qb"}, qb);
  endtask

  task automatic count_check(input string tag);
    expect_val({28'd0, model_cnt});
    check(tag, {28'd0, wr_count});
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    for (int i = 0; i < 32; i++) model_regs[i] = '0;
    model_cnt = '0;
    rs = '0; rt = '0;
    drive(1'b0, 1'b0, '0, '0, '0);

    // Reset then sweep every index on both ports.
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) read_check(AW'(i), AW'(31 - i), "rst_sweep");
    count_check("rst_count");

    // ALU writeback.
    drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h12345678);
    expect_val(32'hDEADBEEF);
    #1 check("wb_alu", wbData);
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    read_check(5'd5, 5'd5, "alu_r5");
    count_check("alu_count");

    // Load writeback.
    drive(1'b1, 1'b1, 5'd9, 32'h0, 32'h000000A5);
    expect_val(32'h000000A5);
    #1 check("wb_load", wbData);
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    read_check(5'd9, 5'd5, "load_r9");

    // r0 protection, including the same-cycle read of r0.
    drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
    read_check(5'd0, 5'd0, "r0_write_cycle");
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    read_check(5'd0, 5'd9, "r0_after");
    count_check("r0_count");

    // Same-cycle read/write of r3.
    drive(1'b1, 1'b0, 5'd3, 32'h11, 32'h0);
    step();
    drive(1'b1, 1'b0, 5'd3, 32'h22, 32'h0);
    rs = 5'd3; rt = 5'd3;
`ifdef REGFILE_BYPASS_EN
    expect_val(32'h22); expect_val(32'h22);
`else
    expect_val(32'h11); expect_val(32'h11);
`endif
    #1;
    check("rw_same_qa", qa);
    check("rw_same_qb", qb);
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    read_check(5'd3, 5'd3, "rw_after");
    count_check("rw_count");

    // Reset colliding with a write to r7.
    rst = 1'b1;
    drive(1'b1, 1'b0, 5'd7, 32'h55, 32'h0);
    expect_val(32'h55);
    #1 check("rst_wbdata", wbData);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    read_check(5'd7, 5'd3, "rst_collide");
    count_check("rst_collide_count");

    // Counter wrap on the 4-bit build: 17 writes land on a count of 1.
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 1'b0, 5'd1, DW'(i + 100), 32'h0);
      step();
    end
    drive(1'b0, 1'b0, 5'd1, 32'hBAD0BAD0, 32'hBAD0BAD0);
    count_check("wrap_count");
    expect_val(32'd1);
    check("wrap_abs", {28'd0, wr_count});
    for (int i = 0; i < 3; i++) step();
    count_check("idle_count");
    read_check(5'd1, 5'd0, "wrap_r1");

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
